// File: rtl/fetch_unit.sv
// DLPRV32 fetch stage: owns the PC, fetches one word per pass over a req/ack
// handshake and offers {pc_32, instr_out} to the fetch register via cs/rdy.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        cs_F_to_D,
    input  logic        rdy_F_to_D,
    output logic [31:0] pc_32,
    output logic [31:0] instr_out,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_ISSUE   = 3'd0,
        S_WAIT    = 3'd1,
        S_OFFER   = 3'd2,
        S_HOLD_LO = 3'd3,
        S_HOLD_HI = 3'd4
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [15:0] wait_cnt_q;
    logic        redir_pend_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        cs_q;
    logic [31:0] pc_32_q;
    logic [31:0] instr_q;
    logic        err_q;

    logic [31:0] redir_pc_d;
    logic        redir_bad_d;

    assign redir_pc_d  = {redirect_pc[31:2], 2'b00};
    assign redir_bad_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ISSUE;
            pc_q         <= RESET_PC;
            wait_cnt_q   <= 16'd0;
            redir_pend_q <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            cs_q         <= 1'b0;
            pc_32_q      <= 32'd0;
            instr_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            // A redirect always retargets the PC; per-state code decides when it takes effect.
            if (redirect_valid) begin
                pc_q <= redir_pc_d;
                if (redir_bad_d) begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                S_ISSUE: begin
                    if (!redirect_valid && !stall) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                        wait_cnt_q  <= 16'd0;
                        state_q     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        redir_pend_q <= 1'b1;
                    end
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        if (redir_pend_q || redirect_valid) begin
                            redir_pend_q <= 1'b0;
                            state_q      <= S_ISSUE;
                        end else begin
                            instr_q <= imem_rdata;
                            pc_32_q <= pc_q;
                            state_q <= S_OFFER;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                        // On timeout pc_q already holds the retry address (old PC or redirect target).
                        if (wait_cnt_q == WAIT_LAST) begin
                            err_q        <= 1'b1;
                            imem_req_q   <= 1'b0;
                            redir_pend_q <= 1'b0;
                            state_q      <= S_ISSUE;
                        end
                    end
                end

                S_OFFER: begin
                    if (redirect_valid) begin
                        state_q <= S_ISSUE;
                    end else if (rdy_F_to_D) begin
                        cs_q    <= 1'b1;
                        state_q <= S_HOLD_LO;
                    end
                end

                S_HOLD_LO: begin
                    cs_q <= 1'b0;
                    if (redirect_valid) begin
                        redir_pend_q <= 1'b1;
                    end
                    if (!rdy_F_to_D) begin
                        state_q <= S_HOLD_HI;
                    end
                end

                S_HOLD_HI: begin
                    if (redirect_valid) begin
                        redir_pend_q <= 1'b1;
                    end
                    if (rdy_F_to_D) begin
                        if (redir_pend_q || redirect_valid) begin
                            redir_pend_q <= 1'b0;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                        state_q <= S_ISSUE;
                    end
                end

                default: begin
                    state_q <= S_ISSUE;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign cs_F_to_D = cs_q;
    assign pc_32     = pc_32_q;
    assign instr_out = instr_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory and fetch-register responders, table-driven
// single-pass vectors, hand-written corner sequences and a randomized stream.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          MW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        cs_F_to_D;
    logic        rdy_F_to_D = 1'b1;
    logic [31:0] pc_32;
    logic [31:0] instr_out;
    logic        fetch_err;

    fetch_unit #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cs_F_to_D(cs_F_to_D), .rdy_F_to_D(rdy_F_to_D),
        .pc_32(pc_32), .instr_out(instr_out), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Environment knobs and responder state
    int          mem_delay_fixed = 0;   // <0: random 0..5 per request
    bit          mem_never = 1'b0;
    int          busy_fixed = 1;        // <0: random 1..3 per offer
    int          age = 0;
    int          cur_delay = 0;
    int          busy_left = 0;
    int          run_len = 0;
    bit          run_acked = 1'b0;
    bit          prev_cs = 1'b0;
    bit          prev_req = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          timeouts_chosen = 0;
    bit          cs_seen = 1'b0;
    logic [31:0] cs_pc = 32'd0;
    logic [31:0] cs_instr = 32'd0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b", name, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, check invariants, drive responders.
    task automatic cycle();
        @(negedge clk);
        cs_seen = 1'b0;
        if (cs_F_to_D) begin
            chk1("cs_single_pulse", prev_cs, 1'b0);
            cs_seen  = 1'b1;
            cs_pc    = pc_32;
            cs_instr = instr_out;
        end
        if (prev_req && imem_req) chk32("addr_stable", imem_addr, prev_addr);
        if (imem_req) begin
            run_len++;
        end else begin
            if (run_len > 0 && !run_acked) chk32("timeout_len", 32'(run_len), 32'(MW));
            run_len   = 0;
            run_acked = 1'b0;
        end
        prev_cs   = cs_F_to_D;
        prev_req  = imem_req;
        prev_addr = imem_addr;

        if (!imem_req) begin
            age        = 0;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end else begin
            if (age == 0) begin
                cur_delay = (mem_delay_fixed < 0) ? int'($urandom_range(5, 0)) : mem_delay_fixed;
                if (cur_delay >= MW) timeouts_chosen++;
            end
            if (!mem_never && age == cur_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = instr_of(imem_addr);
                run_acked  = 1'b1;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
            age++;
        end

        if (cs_F_to_D) busy_left = (busy_fixed < 0) ? int'($urandom_range(3, 1)) : busy_fixed;
        else if (busy_left > 0) busy_left--;
        rdy_F_to_D = (busy_left == 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run_len   = 0;
        run_acked = 1'b0;
        busy_left = 0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk32({tag, "_addr"}, imem_addr, RPC);
        chk1({tag, "_cs"}, cs_F_to_D, 1'b0);
        chk32({tag, "_pc32"}, pc_32, 32'd0);
        chk32({tag, "_instr"}, instr_out, 32'd0);
        chk1({tag, "_err"}, fetch_err, 1'b0);
    endtask

    task automatic wait_cs(input string tag, input logic [31:0] exp_pc);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!cs_seen && k < 60);
        chk1({tag, "_cs_seen"}, cs_seen, 1'b1);
        chk32({tag, "_pc"}, cs_pc, exp_pc);
        chk32({tag, "_instr"}, cs_instr, instr_of(exp_pc));
    endtask

    // Cycles until imem_req rises again (after going low); counts offers seen on the way.
    task automatic wait_req_rise(output int n_cs);
        bit low;
        low  = !imem_req;
        n_cs = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (cs_seen) n_cs++;
            if (!imem_req) low = 1'b1;
            else if (low) break;
        end
    endtask

    typedef struct {
        int          delay;
        int          busy;
        int          idle;
        int          exp_lat;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[4];

    task automatic redirect_in_wait(input bit same_cycle, input string tag);
        int n_cs;
        mem_delay_fixed = 3;
        busy_fixed      = 1;
        idle(5);
        stall = 1'b0;
        cycle();
        if (!same_cycle) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_2000;
            cycle();
            redirect_valid = 1'b0;
        end else begin
            for (int k = 0; k < 10; k++) begin
                if (imem_ack) break;
                cycle();
            end
            chk1({tag, "_ack_seen"}, imem_ack, 1'b1);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_2000;
            cycle();
            redirect_valid = 1'b0;
        end
        wait_req_rise(n_cs);
        chk32({tag, "_no_cs"}, 32'(n_cs), 32'd0);
        chk1({tag, "_req"}, imem_req, 1'b1);
        chk32({tag, "_addr"}, imem_addr, 32'h0000_2000);
        stall = 1'b1;
        wait_cs({tag, "_offer"}, 32'h0000_2000);
    endtask

    initial begin
        int lat;
        int reqs;
        int hi;
        int n_cs;
        int n_off;
        logic [31:0] exp_pc;

        vecs[0] = '{0, 1, 10, 3, 32'h0000_0100};
        vecs[1] = '{1, 2, 10, 4, 32'h0000_0104};
        vecs[2] = '{3, 3, 10, 6, 32'h0000_0108};
        vecs[3] = '{2, 1, 12, 5, 32'h0000_010C};

        do_reset();
        check_reset_vals("reset");

        // Single passes from a stalled ISSUE: no request while stalled, then measured latency.
        for (int i = 0; i < 4; i++) begin
            mem_delay_fixed = vecs[i].delay;
            busy_fixed      = vecs[i].busy;
            reqs = 0;
            for (int k = 0; k < vecs[i].idle; k++) begin
                cycle();
                if (imem_req) reqs++;
            end
            chk32($sformatf("v%0d_stall_no_req", i), 32'(reqs), 32'd0);
            stall = 1'b0;
            cycle();
            lat = 1;
            stall = 1'b1;
            chk1($sformatf("v%0d_first_req", i), imem_req, 1'b1);
            chk32($sformatf("v%0d_first_addr", i), imem_addr, vecs[i].exp_pc);
            while (!cs_seen && lat < 20) begin
                cycle();
                lat++;
            end
            chk32($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk32($sformatf("v%0d_pc", i), cs_pc, vecs[i].exp_pc);
            chk32($sformatf("v%0d_instr", i), cs_instr, instr_of(vecs[i].exp_pc));
            chk1($sformatf("v%0d_err", i), fetch_err, 1'b0);
        end

        redirect_in_wait(1'b0, "redir_wait");
        redirect_in_wait(1'b1, "redir_ack");

        // Timeout: request held exactly MW cycles, error on drop, retry at same PC.
        mem_never = 1'b1;
        idle(5);
        stall = 1'b0;
        cycle();
        chk1("to_req", imem_req, 1'b1);
        chk32("to_addr", imem_addr, 32'h0000_2004);
        chk1("to_err_before", fetch_err, 1'b0);
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (imem_req) hi++;
            else break;
        end
        chk32("to_req_len", 32'(hi), 32'(MW));
        chk1("to_err", fetch_err, 1'b1);
        wait_req_rise(n_cs);
        chk1("to_retry_req", imem_req, 1'b1);
        chk32("to_retry_addr", imem_addr, 32'h0000_2004);
        stall = 1'b1;
        do_reset();
        check_reset_vals("rst_wait");
        mem_never = 1'b0;

        // Reset in HOLD_HI while the fetch register is busy.
        mem_delay_fixed = 0;
        busy_fixed      = 50;
        stall = 1'b0;
        cycle();
        stall = 1'b1;
        wait_cs("hold_pass", RPC);
        idle(2);
        do_reset();
        check_reset_vals("rst_hold");
        n_cs = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (cs_seen) n_cs++;
        end
        chk32("rst_hold_no_cs", 32'(n_cs), 32'd0);
        busy_fixed = 1;
        stall = 1'b0;
        cycle();
        stall = 1'b1;
        wait_cs("after_hold_rst", RPC);

        // PC wrap and misaligned redirect.
        idle(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        chk1("wrap_no_err", fetch_err, 1'b0);
        stall = 1'b0;
        cycle();
        chk32("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        wait_cs("wrap_offer", 32'hFFFF_FFFC);
        wait_req_rise(n_cs);
        chk32("wrap_addr", imem_addr, 32'h0000_0000);
        stall = 1'b1;
        wait_cs("wrap_zero", 32'h0000_0000);
        idle(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        cycle();
        redirect_valid = 1'b0;
        chk1("misalign_err", fetch_err, 1'b1);
        stall = 1'b0;
        cycle();
        stall = 1'b1;
        chk1("misalign_req", imem_req, 1'b1);
        chk32("misalign_addr", imem_addr, 32'h0000_0004);
        wait_cs("misalign_offer", 32'h0000_0004);

        // Randomized stream: sequential PCs regardless of stalls, latencies and timeouts.
        do_reset();
        timeouts_chosen = 0;
        mem_delay_fixed = -1;
        busy_fixed      = -1;
        exp_pc = RPC;
        n_off  = 0;
        for (int k = 0; k < 5000 && n_off < 40; k++) begin
            stall = ($urandom_range(3, 0) == 0);
            cycle();
            if (cs_seen) begin
                chk32($sformatf("rand_pc%0d", n_off), cs_pc, exp_pc);
                chk32($sformatf("rand_instr%0d", n_off), cs_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_off++;
            end
        end
        chk32("rand_count", 32'(n_off), 32'd40);
        chk1("rand_err", fetch_err, (timeouts_chosen > 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage of the DLPRV32 core: owns the program counter, reads one 32-bit instruction per pass from instruction memory over a request/acknowledge handshake, and offers the instruction and its PC to the downstream fetch register over the `cs_F_to_D` / `rdy_F_to_D` handshake. It supports:
- control-flow redirects from the execute stage,
- a hazard stall input,
- a bounded memory wait with a sticky error flag.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `MAX_WAIT`, default 255: cycles `imem_req` may stay high without `imem_ack` before timeout; legal range 1..65535.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: instruction memory request, level, registered.
- `imem_addr`  out  32: fetch address, stable while `imem_req`=1.
- `imem_ack`  in  1: memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction word.
- `stall`  in  1: hazard hold; blocks new requests only.
- `redirect_valid`  in  1: one-cycle pulse, PC redirect (branch/jump).
- `redirect_pc`  in  32: redirect target.
- `cs_F_to_D`  out  1: one-cycle valid pulse to the fetch register.
- `rdy_F_to_D`  in  1: fetch register ready (1 idle, 0 busy capturing).
- `pc_32`  out  32: PC of the offered instruction.
- `instr_out`  out  32: offered instruction.
- `fetch_err`  out  1: sticky error; cleared only by `rst`.

## Operation
- All outputs are registered. Internal regs: `pc` (32 bits), `wait_cnt` (16 bits), `redir_pend` (1 bit), state (3 bits).
- Reset values:
  - `pc`=`RESET_PC`, state=ISSUE.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `cs_F_to_D`=0, `pc_32`=0, `instr_out`=0, `fetch_err`=0.
  - `wait_cnt`=0, `redir_pend`=0.
- `rst` wins over every other input in any state, including a request that is in flight.
- ISSUE: if `stall`=0, set `imem_req`<=1, `imem_addr`<=`pc`, `wait_cnt`<=0, then go to WAIT. If `stall`=1, hold.
- WAIT:
  - On `imem_ack`=1: `imem_req`<=0.
    - If `redir_pend`=0: `instr_out`<=`imem_rdata`, `pc_32`<=`pc`, go to OFFER.
    - If `redir_pend`=1: discard the data, clear `redir_pend`, go to ISSUE.
  - Otherwise `wait_cnt`<=`wait_cnt`+1. When `wait_cnt`==`MAX_WAIT`-1 and there is no ack: `fetch_err`<=1, `imem_req`<=0, go to ISSUE. The retry uses the same `pc`, or the redirect target if a redirect is pending.
- OFFER: when `rdy_F_to_D`=1, set `cs_F_to_D`<=1 and go to HOLD_LO.
- HOLD_LO: `cs_F_to_D`<=0. Go to HOLD_HI when `rdy_F_to_D`=0.
- HOLD_HI: when `rdy_F_to_D`=1, the offer is complete.
  - If `redir_pend`=0: `pc`<=`pc`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - If `redir_pend`=1: clear `redir_pend`; `pc` already holds the target.
  - Go to ISSUE.
- Redirect (`redirect_valid`=1), sampled in every state:
  - `pc`<=`{redirect_pc[31:2],2'b00}`.
  - If `redirect_pc[1:0]`≠0, set `fetch_err`<=1.
  - ISSUE or OFFER: go to ISSUE immediately; OFFER produces no `cs_F_to_D`. A redirect in the ISSUE cycle overrides that cycle's request launch; the request issues next cycle at the target.
  - WAIT: set `redir_pend`<=1; `imem_req` and `imem_addr` stay unchanged until ack or timeout. A redirect in the same cycle as `imem_ack` discards that data and goes to ISSUE.
  - HOLD_LO or HOLD_HI: the handshake completes, then ISSUE at the target. Flushing the already-offered word is downstream's job.
- `stall` only gates ISSUE. It does not affect WAIT, OFFER, HOLD_*, or redirects.
- `imem_addr` never changes while `imem_req`=1.

## Timing
- Best case: `stall`=0, ack in the first cycle of the request, `rdy_F_to_D`=1.
  - Edge 1 (ISSUE): `imem_req`=1.
  - Edge 2 (WAIT + ack): data latched.
  - Edge 3 (OFFER): `cs_F_to_D`=1 for exactly one cycle.
- A full pass is therefore at least 3 cycles plus the HOLD handshake, which takes 2 or more cycles with the fetch register.
- `cs_F_to_D` is never high for more than one consecutive cycle. At most one offer is outstanding at a time.
- Timeout: with no ack, `imem_req` stays high for exactly `MAX_WAIT` cycles; `fetch_err` rises on the edge that drops `imem_req`.

## Test plan
- Reset with `RESET_PC`=32'h100, memory acks after 0 cycles, fetch register model attached → offers PC 32'h100, 32'h104, 32'h108 with matching `instr_out`; `cs_F_to_D` is always a one-cycle pulse; `fetch_err`=0.
- `stall`=1 held for 10 cycles in ISSUE → `imem_req` stays 0; first request appears 1 cycle after `stall` falls, at the unchanged PC.
- `redirect_valid` to 32'h2000 while in WAIT, with ack 3 cycles later → data from the old PC is discarded, no `cs_F_to_D`, next `imem_addr`=32'h2000. Repeat with the redirect in the same cycle as ack → identical result.
- `MAX_WAIT`=4, memory never acks → `imem_req` high for exactly 4 cycles, then `fetch_err`=1 and a retry at the same address. Then `rst` → `fetch_err`=0 and `imem_addr`=`RESET_PC`.
- `pc`=32'hFFFF_FFFC, one pass completes → next `imem_addr`=32'h0000_0000. Redirect to 32'h0000_0006 → `fetch_err`=1 and next `imem_addr`=32'h0000_0004.
- Assert `rst` mid-WAIT and mid-HOLD_HI → next cycle all outputs are at their reset values and no `cs_F_to_D` is produced.
